// File: rtl/xm23_pkg.sv
// Shared definitions for the branch predictor: opcode fields, the FIFO
// entry layout and sign-extension helpers for the branch offsets.
package xm23_pkg;

    localparam logic [2:0] OP_BL  = 3'b000;
    localparam logic [2:0] OP_BCC = 3'b001;
    localparam logic [2:0] CC_BRA = 3'b111;

    typedef struct packed {
        logic        pred_taken;
        logic [15:0] alt_pc;
    } br_entry_t;

    function automatic logic [15:0] sext10(input logic [9:0] v);
        return {{6{v[9]}}, v};
    endfunction

    function automatic logic [15:0] sext13(input logic [12:0] v);
        return {{3{v[12]}}, v};
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/decode/resolve signal bundle between the pipeline and the predictor.
interface branch_predictor_if #(
    parameter int CNT_W = 2
);
    logic [15:0]      true_PC;
    logic [15:0]      instr_in;
    logic             fetch_valid;
    logic [7:0]       stall_in;
    logic             decode_disable;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [15:0]      PC_next;
    logic [15:0]      LBPC;
    logic             branch_fail;
    logic             stall_req;
    logic [CNT_W-1:0] pending;

    modport master (
        output true_PC, instr_in, fetch_valid, stall_in, decode_disable,
               resolve_valid, resolve_taken,
        input  PC_next, LBPC, branch_fail, stall_req, pending
    );

    modport slave (
        input  true_PC, instr_in, fetch_valid, stall_in, decode_disable,
               resolve_valid, resolve_taken,
        output PC_next, LBPC, branch_fail, stall_req, pending
    );
endinterface

// File: rtl/br_fifo.sv
// FIFO of unresolved conditional branches. Occupancy comes from a counter,
// so full/empty never depend on pointer equality. Flush beats push/pop.
module br_fifo
    import xm23_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  br_entry_t        wr_data,
    output br_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    br_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents beyond the occupancy are don't-care.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/branch_predictor.sv
// Fast-decode next-PC generator: BL/BRA always taken, conditional branches
// predicted backward-taken/forward-not-taken and queued until resolved.
module branch_predictor
    import xm23_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predictor_if.slave   bus
);
    logic [15:0] seq;
    logic [15:0] target;
    logic        is_bl;
    logic        is_bcc;
    logic        is_bra;
    logic        conditional;
    logic        pred_taken;
    logic        pop_valid;
    logic        mismatch;
    logic        full_eff;
    logic        push_ok;
    logic        push;

    br_entry_t        wr_data;
    br_entry_t        head;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    // Instruction decode and next-PC prediction.
    always_comb begin
        seq         = bus.true_PC + 16'd2;
        is_bl       = bus.fetch_valid && (bus.instr_in[15:13] == OP_BL);
        is_bcc      = bus.fetch_valid && (bus.instr_in[15:13] == OP_BCC);
        is_bra      = is_bcc && (bus.instr_in[12:10] == CC_BRA);
        conditional = is_bcc && !is_bra;
        target      = is_bl ? seq + (sext13(bus.instr_in[12:0]) << 1)
                            : seq + (sext10(bus.instr_in[9:0]) << 1);
        pred_taken  = is_bl || is_bra || (conditional && bus.instr_in[9]);
        wr_data.pred_taken = pred_taken;
        wr_data.alt_pc     = pred_taken ? seq : target;
    end

    // Resolve/push arbitration: any pop frees a slot this cycle, and a
    // mismatch flush drops a simultaneous push.
    always_comb begin
        pop_valid     = bus.resolve_valid && !empty;
        mismatch      = pop_valid && (bus.resolve_taken != head.pred_taken);
        full_eff      = full && !pop_valid;
        push_ok       = conditional && (bus.stall_in == '0) && !bus.decode_disable
                        && !bus.branch_fail && !full_eff;
        push          = push_ok && !mismatch;
        bus.stall_req = conditional && full_eff && !bus.decode_disable;
        if (bus.stall_req)
            bus.PC_next = bus.true_PC;
        else if (pred_taken)
            bus.PC_next = target;
        else
            bus.PC_next = seq;
    end

    // One-cycle mispredict pulse with the recovery address of the popped head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.branch_fail <= 1'b0;
            bus.LBPC        <= '0;
        end else begin
            bus.branch_fail <= mismatch;
            if (mismatch) bus.LBPC <= head.alt_pc;
        end
    end

    br_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop_valid),
        .flush   (mismatch),
        .wr_data (wr_data),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign bus.pending = count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (DEPTH=2).
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    branch_predictor_if #(.CNT_W(2)) bus();

    branch_predictor #(
        .DEPTH (2),
        .CNT_W (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_valid    = 1'b0;
        bus.resolve_valid  = 1'b0;
        bus.resolve_taken  = 1'b0;
        bus.stall_in       = 8'h00;
        bus.decode_disable = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] ins);
        bus.true_PC     = pc;
        bus.instr_in    = ins;
        bus.fetch_valid = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        fetch(16'h1000, 16'h4000);
        #2;
        checks++; if (bus.branch_fail !== 1'b0) begin errors++; $display("FAIL reset_bf got %0b want 0", bus.branch_fail); end
        checks++; if (bus.LBPC !== 16'h0000) begin errors++; $display("FAIL reset_lbpc got %h want 0000", bus.LBPC); end
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", bus.pending); end
        checks++; if (bus.PC_next !== 16'h1002) begin errors++; $display("FAIL reset_pcnext got %h want 1002", bus.PC_next); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", bus.stall_req); end
        tick();
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_empty_resolve();
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        $display("note: resolve_valid with empty FIFO (protocol error), expecting no effect");
        tick();
        bus.resolve_valid = 1'b0;
        checks++; if (bus.branch_fail !== 1'b0) begin errors++; $display("FAIL empty_resolve_bf got %0b want 0", bus.branch_fail); end
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL empty_resolve_pending got %0d want 0", bus.pending); end
    endtask

    task automatic test_bl_bra();
        fetch(16'h1000, 16'h0010);
        #1;
        checks++; if (bus.PC_next !== 16'h1022) begin errors++; $display("FAIL bl_pcnext got %h want 1022", bus.PC_next); end
        tick();
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL bl_pending got %0d want 0", bus.pending); end
        fetch(16'h1000, 16'h3C05);
        #1;
        checks++; if (bus.PC_next !== 16'h100C) begin errors++; $display("FAIL bra_pcnext got %h want 100c", bus.PC_next); end
        tick();
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL bra_pending got %0d want 0", bus.pending); end
        fetch(16'h1000, 16'h1FFF);
        #1;
        checks++; if (bus.PC_next !== 16'h1000) begin errors++; $display("FAIL bl_neg_pcnext got %h want 1000", bus.PC_next); end
        idle();
        #1;
        checks++; if (bus.PC_next !== 16'h1002) begin errors++; $display("FAIL novalid_pcnext got %h want 1002", bus.PC_next); end
    endtask

    task automatic test_backward_hit();
        fetch(16'h1000, 16'h23FC);
        #1;
        checks++; if (bus.PC_next !== 16'h0FFA) begin errors++; $display("FAIL bwd_pcnext got %h want 0ffa", bus.PC_next); end
        tick();
        idle();
        checks++; if (bus.pending !== 2'd1) begin errors++; $display("FAIL bwd_pending got %0d want 1", bus.pending); end
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        tick();
        idle();
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL bwd_pop_pending got %0d want 0", bus.pending); end
        checks++; if (bus.branch_fail !== 1'b0) begin errors++; $display("FAIL bwd_bf got %0b want 0", bus.branch_fail); end
    endtask

    task automatic test_forward_miss();
        fetch(16'h2000, 16'h2005);
        #1;
        checks++; if (bus.PC_next !== 16'h2002) begin errors++; $display("FAIL fwd_pcnext got %h want 2002", bus.PC_next); end
        tick();
        idle();
        checks++; if (bus.pending !== 2'd1) begin errors++; $display("FAIL fwd_pending got %0d want 1", bus.pending); end
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        tick();
        idle();
        checks++; if (bus.branch_fail !== 1'b1) begin errors++; $display("FAIL fwd_bf got %0b want 1", bus.branch_fail); end
        checks++; if (bus.LBPC !== 16'h200C) begin errors++; $display("FAIL fwd_lbpc got %h want 200c", bus.LBPC); end
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL fwd_flush_pending got %0d want 0", bus.pending); end
        tick();
        checks++; if (bus.branch_fail !== 1'b0) begin errors++; $display("FAIL fwd_bf_pulse got %0b want 0", bus.branch_fail); end
    endtask

    task automatic test_push_suppress();
        fetch(16'h1000, 16'h23FC);
        bus.stall_in = 8'h04;
        tick();
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL stall_in_pending got %0d want 0", bus.pending); end
        bus.stall_in       = 8'h00;
        bus.decode_disable = 1'b1;
        tick();
        idle();
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL ddis_pending got %0d want 0", bus.pending); end
    endtask

    task automatic test_full();
        fetch(16'h1000, 16'h23FC);
        tick();
        fetch(16'h2000, 16'h2005);
        tick();
        checks++; if (bus.pending !== 2'd2) begin errors++; $display("FAIL full_pending got %0d want 2", bus.pending); end
        fetch(16'h3000, 16'h2005);
        #1;
        checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL full_stall got %0b want 1", bus.stall_req); end
        checks++; if (bus.PC_next !== 16'h3000) begin errors++; $display("FAIL full_pcnext got %h want 3000", bus.PC_next); end
        tick();
        checks++; if (bus.pending !== 2'd2) begin errors++; $display("FAIL full_nopush got %0d want 2", bus.pending); end
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        #1;
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL full_pop_stall got %0b want 0", bus.stall_req); end
        checks++; if (bus.PC_next !== 16'h3002) begin errors++; $display("FAIL full_pop_pcnext got %h want 3002", bus.PC_next); end
        tick();
        idle();
        checks++; if (bus.pending !== 2'd2) begin errors++; $display("FAIL full_swap_pending got %0d want 2", bus.pending); end
        checks++; if (bus.branch_fail !== 1'b0) begin errors++; $display("FAIL full_swap_bf got %0b want 0", bus.branch_fail); end
    endtask

    task automatic test_flush_race();
        // head is the forward branch at 0x2000 (predicted not taken)
        fetch(16'h4000, 16'h23FC);
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        tick();
        bus.resolve_valid = 1'b0;
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL race_pending got %0d want 0", bus.pending); end
        checks++; if (bus.branch_fail !== 1'b1) begin errors++; $display("FAIL race_bf got %0b want 1", bus.branch_fail); end
        checks++; if (bus.LBPC !== 16'h200C) begin errors++; $display("FAIL race_lbpc got %h want 200c", bus.LBPC); end
        fetch(16'h5000, 16'h23FC);
        tick();
        idle();
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL wrongpath_pending got %0d want 0", bus.pending); end
        checks++; if (bus.branch_fail !== 1'b0) begin errors++; $display("FAIL wrongpath_bf got %0b want 0", bus.branch_fail); end
    endtask

    task automatic test_reset_mid();
        fetch(16'h6000, 16'h23FC);
        tick();
        idle();
        checks++; if (bus.pending !== 2'd1) begin errors++; $display("FAIL mid_pending got %0d want 1", bus.pending); end
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b0;
        tick();
        idle();
        checks++; if (bus.LBPC !== 16'h6002) begin errors++; $display("FAIL mid_lbpc got %h want 6002", bus.LBPC); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.branch_fail !== 1'b0) begin errors++; $display("FAIL mid_rst_bf got %0b want 0", bus.branch_fail); end
        checks++; if (bus.LBPC !== 16'h0000) begin errors++; $display("FAIL mid_rst_lbpc got %h want 0000", bus.LBPC); end
        rst_n = 1'b1;
        fetch(16'h7000, 16'h23FC);
        tick();
        tick();
        checks++; if (bus.pending !== 2'd2) begin errors++; $display("FAIL mid_refill got %0d want 2", bus.pending); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL mid_rst_pending got %0d want 0", bus.pending); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got %0b want 0", bus.stall_req); end
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_empty_resolve();
        test_bl_bra();
        test_backward_hit();
        test_forward_miss();
        test_push_suppress();
        test_full();
        test_flush_race();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fast-decode next-PC generator that drives the program counter's PC_next, LBPC and branch_fail inputs.
- Inspects the fetched word at true_PC and predicts the next PC: BL/BRA always taken; conditional branches use static BTFN (backward taken, forward not taken).
- Holds a small FIFO of unresolved conditional branches, each entry storing the alternate-path PC.
- When execute resolves a branch against its prediction, pulses branch_fail with LBPC set to the recovery address.

Parameters:
DEPTH, 2, max in-flight unresolved conditional branches (power of 2, ≥2)
CNT_W, $clog2(DEPTH+1), width of occupancy counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
true_PC  in  16  current fetch address
instr_in  in  16  instruction word fetched at true_PC
fetch_valid  in  1  instr_in is valid this cycle
stall_in  in  8  pipeline stall vector (any bit set = hold)
decode_disable  in  1  PC init flush in progress; suppress pushes
resolve_valid  in  1  execute resolves the oldest conditional branch this cycle
resolve_taken  in  1  actual outcome of that branch
PC_next  out  16  predicted next fetch address (combinational)
LBPC  out  16  recovery PC, valid while branch_fail=1 (registered)
branch_fail  out  1  one-cycle mispredict pulse (registered)
stall_req  out  1  FIFO full and a new conditional branch is present
pending  out  CNT_W  FIFO occupancy

Behaviour:
- Reset (rst_n=0, async): FIFO empty, pending=0, branch_fail=0, LBPC=0x0000, stall_req=0. PC_next stays combinational.
- Decode, all arithmetic mod 2^16; seq = true_PC+2:
  - BL: instr[15:13]=000. target = seq + (sext13(instr[12:0])<<1). Predict taken. No push.
  - Bcc: instr[15:13]=001, cc=instr[12:10]. target = seq + (sext10(instr[9:0])<<1). cc=111 (BRA): unconditional, taken, no push. Other cc: conditional; predict taken iff instr[9]=1 (negative offset).
  - Anything else, or fetch_valid=0: PC_next=seq.
- PC_next = target if predicted taken, else seq. When stall_req=1, PC_next=true_PC.
- push_ok = fetch_valid & conditional & ~|stall_in & ~decode_disable & ~branch_fail & ~full.
  - branch_fail high marks the current fetch as wrong-path, so no push that cycle.
- On push, enqueue {pred_taken, alt_pc}; alt_pc = seq if predicted taken, else target.
- Resolve: when resolve_valid & ~empty, pop head and compare resolve_taken with pred_taken.
  - Match: pop only.
  - Mismatch: next cycle branch_fail=1 and LBPC=head.alt_pc. In the same edge, clear the whole FIFO (younger entries are wrong-path); pending=0.
  - branch_fail lasts exactly one cycle unless a new mismatch follows.
- resolve_valid with an empty FIFO is ignored: no fail, no pop. The bench flags it as a protocol error.
- Simultaneous push and pop without mismatch: pending unchanged, ordering preserved.
- Simultaneous push and mismatch: the flush wins and the push is dropped.
- stall_req = fetch_valid & conditional & full & ~decode_disable. Combinational; deasserts in the cycle a pop frees a slot.
- Pointers wrap modulo DEPTH. Full/empty come from pending, not from pointer equality.
- Reset asserted mid-operation aborts any pending fail pulse and empties the FIFO.
- stall_in nonzero freezes pushes only; resolves from execute still pop.

Decomposition:
- Shared package xm23_pkg holds:
  - opcode constants OP_BL=3'b000, OP_BCC=3'b001, CC_BRA=3'b111
  - typedef br_entry_t {logic pred_taken; logic [15:0] alt_pc;}
  - functions sext10/sext13
- One sub-module, br_fifo: parameterised DEPTH with push/pop/flush, count, full/empty.
- Decode and the compare logic stay in branch_predictor.

Test Plan:
1. Reset: hold rst_n=0 with true_PC=0x1000 and instr_in=0x4000 (non-branch) → branch_fail=0, LBPC=0x0000, pending=0, PC_next=0x1002.
2. BL and BRA: true_PC=0x1000.
   - instr_in=0x0010 → PC_next=0x1022, pending stays 0.
   - instr_in=0x3C05 → PC_next=0x100C, pending 0.
3. Backward BEQ predicted correctly: true_PC=0x1000, instr_in=0x23FC → PC_next=0x0FFA, pending=1. Resolve with resolve_taken=1 → pending=0, branch_fail stays 0.
4. Forward BEQ mispredict: true_PC=0x2000, instr_in=0x2005 → PC_next=0x2002, pending=1. Resolve with resolve_taken=1 → next cycle branch_fail=1 for 1 cycle, LBPC=0x200C, pending=0.
5. Full FIFO, DEPTH=2:
   - Push two conditional branches → pending=2.
   - Third conditional branch at 0x3000 → stall_req=1, PC_next=0x3000, no push.
   - Resolve (match) → stall_req=0 that cycle, push occurs at the edge, pending=2.
6. Flush races:
   - Two entries, head mismatches while a new conditional is presented → pending=0 next cycle, push dropped.
   - Cycle after (branch_fail=1) a conditional is presented → no push.
   - rst_n pulsed low mid-sequence → pending=0 and branch_fail=0 immediately.
